// File: rtl/fir_pkg.sv
// Shared widths, output limits and the saturating clip used by the FIR output stage.
package fir_pkg;

  localparam int FIR_ACC_W = 40;
  localparam int FIR_OUT_W = 16;
  localparam int SAT_W     = 64;

  localparam logic signed [FIR_OUT_W-1:0] OUT_MAX = {1'b0, {(FIR_OUT_W-1){1'b1}}};
  localparam logic signed [FIR_OUT_W-1:0] OUT_MIN = {1'b1, {(FIR_OUT_W-1){1'b0}}};

  // Clips a sign-extended value to the signed range of a 'width'-bit word.
  function automatic logic signed [SAT_W-1:0] sat_clip(input logic signed [SAT_W-1:0] v,
                                                       input int unsigned width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Output FIFO with a registered head word, occupancy count and drop-on-full report.
module fir_out_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     iclk,
  input  logic                     irst_n,
  input  logic                     i_clr,
  input  logic                     i_wr,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_ready,
  output logic [W-1:0]             o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_fill,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   cnt;
  logic          full;
  logic          rd;
  logic          wr_ok;

  assign o_valid = (cnt != '0);
  assign o_fill  = cnt;
  assign full    = (cnt == FULL_CNT);
  assign rd      = o_valid && i_ready;
  // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign wr_ok   = i_wr && (!full || rd);
  assign o_drop  = i_wr && full && !rd && !i_clr;
  assign rd_nxt  = rd_ptr + 1'b1;

  always_ff @(posedge iclk) begin
    if (wr_ok && !i_clr) mem[wr_ptr] <= i_wdata;
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd)    rd_ptr <= rd_nxt;
      case ({wr_ok, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Head register: loaded from the write only when that word becomes the head,
  // otherwise from the next stored entry; holds its last value once empty.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      o_data <= '0;
    end else if (!i_clr) begin
      if (wr_ok && ((cnt == '0) || ((cnt == (AW+1)'(1)) && rd)))
        o_data <= i_wdata;
      else if (rd && (cnt > (AW+1)'(1)))
        o_data <= mem[rd_nxt];
    end
  end

endmodule

// File: rtl/fir_out_stage.sv
// FIR output stage: capture aligned to sample-valid, warm-up suppression, round/shift/saturate, output FIFO.
// Optional decimation is enabled by defining FIR_DECIM_EN.
module fir_out_stage
  import fir_pkg::*;
#(
  parameter int ACC_W      = FIR_ACC_W,
  parameter int OUT_W      = FIR_OUT_W,
  parameter int FRAC_SHIFT = 7,
  parameter int PIPE_LAT   = 19,
  parameter int WARMUP     = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int DECIM      = 2
) (
  input  logic                          iclk,
  input  logic                          irst_n,
  input  logic                          i_sample_vld,
  input  logic [ACC_W-1:0]              i_result,
  input  logic                          i_flush,
  output logic [OUT_W-1:0]              o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_sat,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fill
);

  localparam int WU_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WU_W-1:0] WU_END = WU_W'(WARMUP);
  localparam logic signed [ACC_W:0] RND = {{ACC_W{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);

  logic [PIPE_LAT-1:0]     dly;
  logic                    cap;
  logic [WU_W-1:0]         wu_cnt;
  logic                    warm;
  logic                    post;
  logic                    take;
  logic signed [ACC_W:0]   acc_ext;
  logic signed [ACC_W:0]   rnd_sum;
  logic signed [ACC_W:0]   r_q;
  logic                    s1_vld;
  logic signed [SAT_W-1:0] r_wide;
  logic signed [SAT_W-1:0] r_clip;
  logic                    sat_hit;
  logic [OUT_W-1:0]        s2_data;
  logic                    s2_vld;
  logic                    fifo_drop;

  generate
    if (PIPE_LAT == 1) begin : g_dly1
      always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n)      dly <= '0;
        else if (i_flush) dly <= '0;
        else              dly <= i_sample_vld;
      end
    end else begin : g_dlyn
      always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n)      dly <= '0;
        else if (i_flush) dly <= '0;
        else              dly <= {dly[PIPE_LAT-2:0], i_sample_vld};
      end
    end
  endgenerate

  assign cap  = dly[PIPE_LAT-1];
  assign warm = (wu_cnt < WU_END);
  assign post = cap && !warm;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n)           wu_cnt <= '0;
    else if (i_flush)      wu_cnt <= '0;
    else if (cap && warm)  wu_cnt <= wu_cnt + 1'b1;
  end

`ifdef FIR_DECIM_EN
  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

  logic [PH_W-1:0] phase;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n)      phase <= '0;
    else if (i_flush) phase <= '0;
    else if (post)    phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
  end

  assign take = post && (phase == '0);
`else
  assign take = post;
`endif

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  assign acc_ext = {i_result[ACC_W-1], i_result};
  assign rnd_sum = acc_ext + RND;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_q    <= '0;
      s1_vld <= 1'b0;
    end else if (i_flush) begin
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= take;
      if (take) r_q <= rnd_sum >>> FRAC_SHIFT;
    end
  end

  assign r_wide  = SAT_W'(r_q);
  assign r_clip  = sat_clip(r_wide, OUT_W);
  assign sat_hit = (r_clip != r_wide);

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      s2_data <= '0;
      s2_vld  <= 1'b0;
    end else if (i_flush) begin
      s2_vld  <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) s2_data <= r_clip[OUT_W-1:0];
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      o_sat      <= 1'b0;
      o_overflow <= 1'b0;
    end else if (i_flush) begin
      o_sat      <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (s1_vld && sat_hit) o_sat      <= 1'b1;
      if (fifo_drop)         o_overflow <= 1'b1;
    end
  end

  fir_out_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iclk    (iclk),
    .irst_n  (irst_n),
    .i_clr   (i_flush),
    .i_wr    (s2_vld),
    .i_wdata (s2_data),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_fill  (o_fill),
    .o_drop  (fifo_drop)
  );

endmodule

// File: tb/tb_fir_out_stage.sv
// Directed bench for fir_out_stage: warm-up, rounding, saturation, backpressure, flush.
module tb_fir_out_stage;
  import fir_pkg::*;

  logic        iclk = 1'b0;
  logic        irst_n = 1'b0;
  logic        i_sample_vld = 1'b0;
  logic [39:0] i_result = '0;
  logic        i_flush = 1'b0;
  logic        i_ready = 1'b1;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_sat;
  logic        o_overflow;
  logic [2:0]  o_fill;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_c = 0;
  logic [39:0] sched [64];
  logic signed [15:0] got_q [$];

  fir_out_stage #(
    .ACC_W(40), .OUT_W(16), .FRAC_SHIFT(7), .PIPE_LAT(19),
    .WARMUP(7), .FIFO_DEPTH(4), .DECIM(2)
  ) dut (
    .iclk(iclk), .irst_n(irst_n), .i_sample_vld(i_sample_vld), .i_result(i_result),
    .i_flush(i_flush), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_sat(o_sat), .o_overflow(o_overflow), .o_fill(o_fill)
  );

  always #5 iclk = ~iclk;

  // Upstream tap chain stand-in: presents each sample's result 19 cycles after its valid.
  always @(posedge iclk) begin
    cyc = cyc + 1;
    #1 i_result = sched[cyc % 64];
  end

  always @(negedge iclk)
    if (irst_n && o_valid && i_ready) got_q.push_back($signed(o_data));

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  task automatic send(input logic signed [39:0] v);
    last_c = cyc;
    sched[(cyc + 19) % 64] = v;
    i_sample_vld = 1'b1;
    tick(1);
    i_sample_vld = 1'b0;
    tick(1);
  endtask

  task automatic wait_until(input int t);
    int guard = 0;
    while (cyc < t && guard < 1000) begin
      tick(1);
      guard++;
    end
  endtask

  function automatic logic signed [63:0] pop();
    if (got_q.size() == 0) return 'x;
    return got_q.pop_front();
  endfunction

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    for (int i = 0; i < 64; i++) sched[i] = '0;
    tick(3);
    @(negedge iclk);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", $signed(o_data), 0);
    chk("rst_fill", o_fill, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_ovf", o_overflow, 0);
    tick(1);
    irst_n = 1'b1;
    tick(2);

`ifdef FIR_DECIM_EN
    for (int i = 0; i < 7; i++) send(640);
    send(640);
    send(768);
    send(896);
    tick(30);
    chk("dec_count", got_q.size(), 2);
    chk("dec_0", pop(), 5);
    chk("dec_1", pop(), 7);
`else
    // Warm-up: only the 8th capture comes out, 22 cycles after its valid.
    for (int i = 0; i < 8; i++) send(640);
    wait_until(last_c + 21);
    @(negedge iclk);
    chk("lat_early", o_valid, 0);
    tick(1);
    @(negedge iclk);
    chk("lat_valid", o_valid, 1);
    chk("lat_data", $signed(o_data), 5);
    tick(3);
    chk("warm_count", got_q.size(), 1);
    chk("warm_data", pop(), 5);

    send(192);
    send(-192);
    tick(25);
    chk("rnd_pos", pop(), 2);
    chk("rnd_neg", pop(), -1);
    chk("rnd_sat", o_sat, 0);

    send(8388608);
    send(-8388736);
    tick(25);
    chk("sat_max", pop(), 32767);
    chk("sat_min", pop(), -32768);
    chk("sat_flag", o_sat, 1);
    tick(10);
    chk("sat_sticky", o_sat, 1);

    // Backpressure: six results into a four-deep FIFO.
    i_ready = 1'b0;
    for (int k = 10; k < 16; k++) send(128 * k);
    tick(25);
    @(negedge iclk);
    chk("bp_fill", o_fill, 4);
    chk("bp_ovf", o_overflow, 1);
    chk("bp_valid", o_valid, 1);
    chk("bp_head", $signed(o_data), 10);
    chk("bp_none", got_q.size(), 0);
    tick(1);
    i_ready = 1'b1;
    tick(8);
    for (int k = 10; k < 14; k++) chk("bp_order", pop(), k);
    chk("bp_drained", got_q.size(), 0);
    chk("bp_fill0", o_fill, 0);

    // Flush with flags set, one word buffered and three results in flight.
    i_ready = 1'b0;
    send(384);
    send(8388608);
    tick(25);
    chk("pre_flush_sat", o_sat, 1);
    chk("pre_flush_fill", o_fill, 2);
    send(640);
    send(640);
    send(640);
    i_flush = 1'b1;
    tick(1);
    i_flush = 1'b0;
    @(negedge iclk);
    chk("fl_valid", o_valid, 0);
    chk("fl_fill", o_fill, 0);
    chk("fl_sat", o_sat, 0);
    chk("fl_ovf", o_overflow, 0);
    tick(1);
    i_ready = 1'b1;
    tick(40);
    chk("fl_lost", got_q.size(), 0);
    for (int i = 0; i < 7; i++) send(640);
    send(1280);
    tick(25);
    chk("fl_warm_count", got_q.size(), 1);
    chk("fl_warm_data", pop(), 10);

    // Full FIFO with a read and a write in the same cycle.
    i_ready = 1'b0;
    for (int k = 20; k < 24; k++) send(128 * k);
    tick(25);
    chk("full_fill", o_fill, 4);
    send(128 * 24);
    wait_until(last_c + 21);
    i_ready = 1'b1;
    @(negedge iclk);
    chk("simul_pre", o_fill, 4);
    tick(1);
    i_ready = 1'b0;
    @(negedge iclk);
    chk("simul_fill", o_fill, 4);
    chk("simul_ovf", o_overflow, 0);
    chk("simul_head", $signed(o_data), 21);
    tick(1);
    i_ready = 1'b1;
    tick(8);
    for (int k = 20; k < 25; k++) chk("simul_order", pop(), k);
    chk("simul_ovf_end", o_overflow, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
